stream_demux: RTL
=================

Name: stream_demux

Overview:
- 1-to-2 demultiplexer for 32-bit data words with valid/ready handshakes; the inverse of the 2:1 word multiplexer used on the datapath.
- Steers each accepted input word to output port 0 or 1 according to a per-word select bit.
- Each output has its own FIFO, so a stalled consumer does not block traffic bound for the other port.
- Per-port word counters are provided for debug and performance observation.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO; must be a power of 2 and ≥2.
- CNT_W, 16, width of the per-port delivered-word counters.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input word valid.
- s_ready  output  1  block can accept the word currently presented.
- s_sel  input  1  destination of the input word: 0 selects m0, 1 selects m1; qualified by s_valid.
- s_data  input  WIDTH  input word.
- m0_valid  output  1  port 0 holds a word.
- m0_ready  input  1  port 0 consumer accepts.
- m0_data  output  WIDTH  port 0 head word.
- m1_valid  output  1  port 1 holds a word.
- m1_ready  input  1  port 1 consumer accepts.
- m1_data  output  WIDTH  port 1 head word.
- cnt0  output  CNT_W  number of words popped from port 0.
- cnt1  output  CNT_W  number of words popped from port 1.

Behaviour:
- Reset (rst_n low, asynchronous): both FIFOs are emptied and all pointers cleared. m0_valid, m1_valid, m0_data, m1_data, cnt0 and cnt1 are 0. s_ready stays 0 while rst_n is low.
- Reset release: s_ready is 1 from the first clock edge after rst_n rises. Any in-flight words are discarded.
- Accept: a word is accepted on a rising edge when s_valid=1 and s_ready=1. It is written into the FIFO chosen by s_sel.
- s_ready: combinational, equal to NOT full of the FIFO addressed by s_sel. The full flag is registered state, so a pop in the same cycle does not make room for a push into a full FIFO. No pass-through path exists.
- Latency: a word accepted in cycle N is visible as mX_valid=1 with mX_data set in cycle N+1. Minimum latency is 1 cycle.
- Outputs: mX_valid = NOT empty of FIFO X. mX_data = head entry when valid, 0 when empty.
- Pop: FIFO X pops on a rising edge when mX_valid=1 and mX_ready=1. Once asserted, mX_valid and mX_data stay stable until the pop occurs.
- Ordering: words are delivered in acceptance order within each port. No ordering relation exists between the two ports.
- Simultaneous push and pop on the same non-full FIFO: both take effect and the occupancy count is unchanged.
- A push to one port may coincide with a pop from the other port.
- FIFO implementation: read and write pointers of log2(DEPTH)+1 bits with wrap-around.
  - empty when the pointers are equal.
  - full when the MSBs differ and the lower bits are equal.
- Counters: cntX increments by 1 on each pop of port X and wraps from 2^CNT_W−1 to 0. Pushes do not affect the counters.
- Sustained rate: with mX_ready held at 1, the block carries 1 word per cycle to a single port indefinitely.
- Inputs: s_sel and s_data are ignored when s_valid=0. Undefined values on them while s_valid=0 must not affect state.

Test Plan:
- Reset, then s_valid=1, s_sel=0, s_data=0xDEADBEEF, m0_ready=1 → next cycle m0_valid=1 and m0_data=0xDEADBEEF; m1_valid stays 0; cnt0=1 after the pop.
- Backpressure: m1_ready=0, push 0x1, 0x2, 0x3 to port 1 (DEPTH=2) → s_ready drops after 2 accepts while s_sel=1; s_ready=1 while s_sel=0; 0x3 is accepted only after m1_ready is raised; pops are in the order 0x1, 0x2, 0x3.
- Isolation: port 1 full and stalled, stream 0x10–0x17 to port 0 with m0_ready=1 → all 8 words delivered in order at 1 word/cycle; cnt0=8, cnt1=0.
- Full plus simultaneous pop: port 0 full, m0_ready=1, s_valid=1, s_sel=0 → s_ready=0 that cycle; next cycle s_ready=1.
- Counter wrap: CNT_W=4, pop 17 words from port 0 → cnt0=1.
- Reset mid-operation: both FIFOs hold 2 words, assert rst_n=0 between edges → immediately m0_valid=m1_valid=0, data=0, cnt0=cnt1=0, s_ready=0; after release the old words never appear.

Source files
------------

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux
// Description : 1-to-2 valid/ready word demultiplexer. Each accepted word is
//               steered by s_sel into one of two per-port FIFOs so a stalled
//               consumer never blocks the other port. Per-port pop counters
//               are exposed for debug/performance observation.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux #(
    parameter int WIDTH = 32,  // data word width
    parameter int DEPTH = 2,   // entries per output FIFO, power of 2, >= 2
    parameter int CNT_W = 16   // width of the per-port delivered-word counters
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_sel,
    input  logic [WIDTH-1:0] s_data,
    output logic             m0_valid,
    input  logic             m0_ready,
    output logic [WIDTH-1:0] m0_data,
    output logic             m1_valid,
    input  logic             m1_ready,
    output logic [WIDTH-1:0] m1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    // Address bits into a FIFO and pointer width (one extra wrap bit).
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic                   ready_en_q;
    logic                   ready_en_d;
    logic [1:0]             w_push;
    logic [1:0]             w_pop;
    logic [1:0]             w_full;
    logic [1:0]             w_empty;
    logic [1:0]             w_m_ready;
    logic [1:0][WIDTH-1:0]  w_head;
    logic [1:0][CNT_W-1:0]  w_cnt;

    // Input acceptance is held off until the first clock edge after reset is
    // released, so s_ready is low throughout reset and during the release cycle.
    always_comb begin
        ready_en_d = 1'b1;
    end

    // Reset-qualified enable flop for the input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= ready_en_d;
        end
    end

    // Ready depends only on the registered full flag of the addressed FIFO;
    // a pop in the same cycle deliberately does not open a slot.
    assign s_ready   = ready_en_q & ~(s_sel ? w_full[1] : w_full[0]);
    assign w_m_ready = {m1_ready, m0_ready};

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_port
            localparam logic PORT_SEL = (p == 1);

            logic [PW-1:0]    wr_ptr_q;
            logic [PW-1:0]    wr_ptr_d;
            logic [PW-1:0]    rd_ptr_q;
            logic [PW-1:0]    rd_ptr_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [WIDTH-1:0] mem_d [DEPTH];

            // Wrap-bit pointer compare: equal means empty, equal index with
            // differing wrap bit means full.
            assign w_empty[p] = (wr_ptr_q == rd_ptr_q);
            assign w_full[p]  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

            assign w_push[p]  = s_valid & s_ready & (s_sel == PORT_SEL);
            assign w_pop[p]   = ~w_empty[p] & w_m_ready[p];

            // Head word is forced to zero while the FIFO is empty.
            assign w_head[p]  = w_empty[p] ? '0 : mem_q[rd_ptr_q[AW-1:0]];
            assign w_cnt[p]   = cnt_q;

            // Next-state for storage, pointers and the pop counter.
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                cnt_d    = cnt_q;
                mem_d    = mem_q;
                if (w_push[p]) begin
                    mem_d[wr_ptr_q[AW-1:0]] = s_data;
                    wr_ptr_d                = wr_ptr_q + PW'(1);
                end
                if (w_pop[p]) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end

            // Pointer and counter registers; clearing the pointers discards
            // any words still held in storage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                end
            end

            // Storage needs no reset: its contents are masked while empty.
            always_ff @(posedge clk) begin
                mem_q <= mem_d;
            end
        end
    endgenerate

    assign m0_valid = ~w_empty[0];
    assign m1_valid = ~w_empty[1];
    assign m0_data  = w_head[0];
    assign m1_data  = w_head[1];
    assign cnt0     = w_cnt[0];
    assign cnt1     = w_cnt[1];

endmodule
`default_nettype wire
